// File: rtl/riv_async_fifo_rd_stream_if.sv
// Handshake bundle between the LUTRAM async FIFO read port, the read-side
// stream adapter and the downstream consumer.
interface riv_async_fifo_rd_stream_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_rdata;
   logic                  fifo_ren;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic [1:0]            occupancy;
   logic [31:0]           beat_count;
   logic [31:0]           stall_count;

   // master: the adapter itself
   modport master (
      input  fifo_empty, fifo_rdata, m_ready,
      output fifo_ren, m_valid, m_data, occupancy, beat_count, stall_count
   );

   // slave: FIFO plus downstream consumer as seen from outside the adapter
   modport slave (
      output fifo_empty, fifo_rdata, m_ready,
      input  fifo_ren, m_valid, m_data, occupancy, beat_count, stall_count
   );
endinterface

// File: rtl/riv_async_fifo_rd_stream.sv
// Read-side FIFO adapter: 2-entry registered buffer turning the LUTRAM FIFO's
// combinational read port into a valid/ready stream. Optional counters: RIV_ASYNC_FIFO_RD_STREAM_STATS_EN.
module riv_async_fifo_rd_stream #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                               clk,
   input  logic                               rst_n,
   riv_async_fifo_rd_stream_if.master         bus
);

   logic [DATA_WIDTH-1:0] mem [2];
   logic [1:0]            count;
   logic                  head;
   logic                  tail;
   logic                  push;
   logic                  pop;

   // Read request ignores m_ready so the FIFO side never waits on the consumer;
   // gated by rst_n so nothing is requested while reset is held.
   assign push = rst_n && !bus.fifo_empty && (count != 2'd2);
   assign pop  = (count != 2'd0) && bus.m_ready;

   assign bus.fifo_ren  = push;
   assign bus.m_valid   = (count != 2'd0);
   assign bus.m_data    = mem[head];
   assign bus.occupancy = count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 2'd0;
         head  <= 1'b0;
         tail  <= 1'b0;
      end else begin
         if (push) tail <= ~tail;
         if (pop)  head <= ~head;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Data entries carry no reset; only the pointers/count define validity.
   always_ff @(posedge clk) begin
      if (push) mem[tail] <= bus.fifo_rdata;
   end

`ifdef RIV_ASYNC_FIFO_RD_STREAM_STATS_EN
   logic [31:0] beat_q;
   logic [31:0] stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_q  <= 32'd0;
         stall_q <= 32'd0;
      end else begin
         if (pop)                         beat_q  <= beat_q + 32'd1;
         if (bus.m_valid && !bus.m_ready) stall_q <= stall_q + 32'd1;
      end
   end

   assign bus.beat_count  = beat_q;
   assign bus.stall_count = stall_q;
`else
   assign bus.beat_count  = 32'd0;
   assign bus.stall_count = 32'd0;
`endif

endmodule
